panda_serial_shifter: RTL and testbench

- Multi-cycle, area-reduced shifter for small Panda configurations: sequential counterpart of the single-cycle barrel shifter.
- Shifts one bit position per clock and supports SLL/SRL/SRA.
- Sits in the execute stage behind a valid/ready request interface and a valid/ready result interface; the pipeline stalls while it is busy.
- Supports a synchronous flush for branch/exception kill.

---
 rtl/panda_serial_shifter_pkg.sv | 16 +
 rtl/panda_serial_shifter_if.sv | 26 ++
 rtl/panda_serial_shifter.sv | 74 +++++++
 tb/tb_panda_serial_shifter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/panda_serial_shifter_pkg.sv
// Shared types and constants for the multi-cycle Panda shifter.
// The direction/type encodings match what the ALU decoder drives onto left_i/arithmetic_i.
package panda_serial_shifter_pkg;

    typedef enum logic [1:0] {
        ShIdle,
        ShBusy,
        ShDone
    } shift_state_e;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_ARITH = 1'b1;
    localparam logic SHIFT_LOGIC = 1'b0;

endpackage

// File: rtl/panda_serial_shifter_if.sv
// Request/result handshake bundle between the execute stage and the serial shifter.
// master = pipeline side, slave = shifter side.
interface panda_serial_shifter_if #(
    parameter int Width       = 32,
    parameter int AmountWidth = $clog2(Width)
);
    logic                   valid_i;
    logic                   ready_o;
    logic                   left_i;
    logic                   arithmetic_i;
    logic [Width-1:0]       operand_i;
    logic [AmountWidth-1:0] amount_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [Width-1:0]       result_o;

    modport master (
        output valid_i, left_i, arithmetic_i, operand_i, amount_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, left_i, arithmetic_i, operand_i, amount_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/panda_serial_shifter.sv
// Purpose: SLL/SRL/SRA one bit position per clock behind valid/ready request and result ports.
// Latency: result valid A+1 cycles after accept (A = shift amount); one op per A+2 cycles at best.
// Backpressure: ready_o only in IDLE; result held in DONE until ready_i; flush_i kills anything.
module panda_serial_shifter
    import panda_serial_shifter_pkg::*;
#(
    parameter int Width       = 32,
    parameter int AmountWidth = $clog2(Width)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    panda_serial_shifter_if.slave  bus
);

    shift_state_e           state_q, state_d;
    logic [Width-1:0]       data_q;
    logic [AmountWidth-1:0] cnt_q;
    logic                   left_q;
    logic                   sign_q;
    logic                   accept;

    assign bus.ready_o  = (state_q == ShIdle);
    assign bus.valid_o  = (state_q == ShDone);
    assign bus.result_o = data_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ShIdle: begin
                if (bus.valid_i) begin
                    accept  = 1'b1;
                    state_d = (bus.amount_i == '0) ? ShDone : ShBusy;
                end
            end
            ShBusy: begin
                if (cnt_q == AmountWidth'(1)) state_d = ShDone;
            end
            ShDone: begin
                if (bus.ready_i) state_d = ShIdle;
            end
            default: state_d = ShIdle;
        endcase
        // Kill wins over both a new capture and the result handshake.
        if (flush_i) begin
            state_d = ShIdle;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ShIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= bus.operand_i;
                cnt_q  <= bus.amount_i;
                left_q <= bus.left_i;
                sign_q <= bus.arithmetic_i & (bus.left_i == SHIFT_RIGHT) & bus.operand_i[Width-1];
            end else if (state_q == ShBusy && !flush_i) begin
                data_q <= (left_q == SHIFT_LEFT) ? {data_q[Width-2:0], 1'b0}
                                                 : {sign_q, data_q[Width-1:1]};
                cnt_q  <= cnt_q - AmountWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_panda_serial_shifter.sv
// Directed plus randomized checks of panda_serial_shifter against an arithmetic shift model.
module tb_panda_serial_shifter;
    import panda_serial_shifter_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic flush_i = 1'b0;

    int checks = 0;
    int errors = 0;

    panda_serial_shifter_if #(.Width(W), .AmountWidth(AW)) bus ();

    panda_serial_shifter #(.Width(W), .AmountWidth(AW)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] model(input logic [W-1:0] op, input int amt,
                                           input logic left, input logic arith);
        logic signed [W-1:0] s;
        s = op;
        if (left)       return op << amt;
        else if (arith) return s >>> amt;
        else            return op >> amt;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic garble();
        bus.valid_i      = 1'($urandom);
        bus.left_i       = 1'($urandom);
        bus.arithmetic_i = 1'($urandom);
        bus.operand_i    = $urandom;
        bus.amount_i     = AW'($urandom);
    endtask

    // Issue one op at a negedge in IDLE, time it, hold the result for `stall` cycles, then consume.
    task automatic run_op(input string tag, input logic [W-1:0] op, input int amt,
                          input logic left, input logic arith, input int stall);
        logic [W-1:0] exp;
        int cycles;
        exp = model(op, amt, left, arith);
        check({tag, " ready_before"}, W'(bus.ready_o), W'(1));
        bus.valid_i      = 1'b1;
        bus.operand_i    = op;
        bus.amount_i     = AW'(amt);
        bus.left_i       = left;
        bus.arithmetic_i = arith;
        bus.ready_i      = 1'b0;
        @(negedge clk_i);
        garble();
        cycles = 1;
        while (!bus.valid_o && cycles < 100) begin
            if (bus.ready_o) begin
                check({tag, " ready_low_busy"}, W'(bus.ready_o), W'(0));
            end
            @(negedge clk_i);
            garble();
            cycles++;
        end
        check({tag, " latency"}, W'(cycles), W'(amt + 1));
        check({tag, " result"}, bus.result_o, exp);
        for (int i = 0; i < stall; i++) begin
            bus.valid_i = 1'b1;
            @(negedge clk_i);
            check({tag, " hold_valid"}, W'(bus.valid_o), W'(1));
            check({tag, " hold_result"}, bus.result_o, exp);
            check({tag, " hold_noaccept"}, W'(bus.ready_o), W'(0));
        end
        bus.ready_i = 1'b1;
        @(negedge clk_i);
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b0;
        check({tag, " idle_valid"}, W'(bus.valid_o), W'(0));
        check({tag, " idle_ready"}, W'(bus.ready_o), W'(1));
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.left_i = 1'b0;
        bus.arithmetic_i = 1'b0; bus.operand_i = '0; bus.amount_i = '0;

        #12;
        check("reset ready", W'(bus.ready_o), W'(1));
        check("reset valid", W'(bus.valid_o), W'(0));
        check("reset result", bus.result_o, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op("srl4",   32'h8000_00F0, 4,  SHIFT_RIGHT, SHIFT_LOGIC, 0);
        check("srl4 value", bus.result_o, 32'h0800_000F);
        run_op("sra31",  32'h8000_0000, 31, SHIFT_RIGHT, SHIFT_ARITH, 0);
        check("sra31 value", bus.result_o, 32'hFFFF_FFFF);
        run_op("sll31",  32'h0000_0001, 31, SHIFT_LEFT,  SHIFT_LOGIC, 1);
        check("sll31 value", bus.result_o, 32'h8000_0000);
        run_op("amt0",   32'h1234_5678, 0,  SHIFT_RIGHT, SHIFT_LOGIC, 0);
        run_op("amt0la", 32'h1234_5678, 0,  SHIFT_LEFT,  SHIFT_ARITH, 0);
        check("amt0la value", bus.result_o, 32'h1234_5678);
        run_op("bp10",   32'hDEAD_BEEF, 7,  SHIFT_RIGHT, SHIFT_ARITH, 10);
        run_op("after_bp", 32'h0F00_0001, 3, SHIFT_LEFT, SHIFT_LOGIC, 0);

        // Flush in the second BUSY cycle of an amount-8 op.
        bus.valid_i = 1'b1; bus.operand_i = 32'hAAAA_5555; bus.amount_i = 5'd8;
        bus.left_i = 1'b0; bus.arithmetic_i = 1'b0;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_busy ready", W'(bus.ready_o), W'(1));
        for (int i = 0; i < 10; i++) begin
            if (bus.valid_o) check("flush_busy no_valid", W'(bus.valid_o), W'(0));
            @(negedge clk_i);
        end
        check("flush_busy still_idle", W'(bus.ready_o), W'(1));

        // Flush together with a request in IDLE: amount 0 would otherwise show valid_o next cycle.
        bus.valid_i = 1'b1; bus.amount_i = 5'd0; flush_i = 1'b1;
        @(negedge clk_i);
        bus.valid_i = 1'b0; flush_i = 1'b0;
        check("flush_idle valid", W'(bus.valid_o), W'(0));
        check("flush_idle ready", W'(bus.ready_o), W'(1));

        // Flush in DONE drops the result even with ready_i high.
        bus.valid_i = 1'b1; bus.operand_i = 32'h0000_00FF; bus.amount_i = 5'd1;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_done pre", W'(bus.valid_o), W'(1));
        flush_i = 1'b1; bus.ready_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; bus.ready_i = 1'b0;
        check("flush_done valid", W'(bus.valid_o), W'(0));
        check("flush_done ready", W'(bus.ready_o), W'(1));

        // Asynchronous reset mid-BUSY.
        bus.valid_i = 1'b1; bus.operand_i = 32'h1357_9BDF; bus.amount_i = 5'd20;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("arst valid", W'(bus.valid_o), W'(0));
        check("arst ready", W'(bus.ready_o), W'(1));
        check("arst result", bus.result_o, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_op("post_rst", 32'hF0F0_F0F0, 4, SHIFT_RIGHT, SHIFT_LOGIC, 0);
        check("post_rst value", bus.result_o, 32'h0F0F_0F0F);

        for (int n = 0; n < 40; n++) begin
            run_op("rand", $urandom, int'($urandom_range(0, W - 1)),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
